alu_mdu: RTL

Parametrised successor to the single-cycle integer ALU: executes all RV base integer register-register operations plus the M-extension multiply/divide set under a valid/ready handshake. Base ops complete in one cycle; multiply and divide use an iterative shift-add / restoring-divide datapath of XLEN steps. Sits in the execute stage; the pipeline stalls while `o_ready` is low.

---
 rtl/alu_mdu.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/alu_mdu.sv
// Execute-stage integer unit: single-cycle base ALU ops plus iterative
// multiply (shift-add) and restoring divide behind a valid/ready handshake.
module alu_mdu #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_m,
  input  logic [2:0]      i_op,
  input  logic            i_op2,
  input  logic [XLEN-1:0] i_x,
  input  logic [XLEN-1:0] i_y,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero,
  output logic [2:0]      o_dbg_state
);

  localparam int SHW = $clog2(XLEN);

  // Handshake: a request is accepted on any rising edge where i_valid && o_ready;
  // a result is retired on any rising edge where o_valid && i_ready.
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [SHW-1:0]        cnt_q;
  logic [2*XLEN-1:0]     p_q;
  logic [XLEN-1:0]       a_q;
  logic [2:0]            op_q;
  logic                  div_q, neg_q;
  logic [XLEN-1:0]       res_q;
  logic                  zero_q;

  logic                  accept, is_mul, is_div, div_zero, div_ovf, special;
  logic                  x_signed, y_signed, x_sgn, y_sgn, neg_d;
  logic [XLEN-1:0]       mag_x, mag_y, alu_res, imm_res, fix_res, res_d;
  logic [SHW-1:0]        shamt;
  logic [XLEN:0]         mul_sum, div_sh;
  logic [XLEN+1:0]       div_diff;
  logic [2*XLEN-1:0]     step_d, mul_fix;
  logic [XLEN-1:0]       div_sel, div_fix;
  logic                  res_load;

  assign accept = i_valid && o_ready;
  assign is_mul = i_m && !i_op[2];
  assign is_div = i_m && i_op[2];
  assign shamt  = i_y[SHW-1:0];

  always_comb begin
    x_signed = is_mul ? (i_op != 3'b011) : (is_div && !i_op[0]);
    y_signed = is_mul ? (i_op[2:1] == 2'b00) : (is_div && !i_op[0]);
    x_sgn    = x_signed && i_x[XLEN-1];
    y_sgn    = y_signed && i_y[XLEN-1];
    mag_x    = x_sgn ? -i_x : i_x;
    mag_y    = y_sgn ? -i_y : i_y;
    // Remainder follows the dividend; quotient and products follow x^y.
    neg_d    = (is_div && i_op[1]) ? x_sgn : (x_sgn ^ y_sgn);
    div_zero = is_div && (i_y == '0);
    div_ovf  = is_div && !i_op[0] && (i_x == {1'b1, {(XLEN-1){1'b0}}}) && (&i_y);
    special  = div_zero || div_ovf;
  end

  always_comb begin
    alu_res = '0;
    case (i_op)
      3'b000: alu_res = i_op2 ? (i_x - i_y) : (i_x + i_y);
      3'b001: alu_res = i_x << shamt;
      3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(i_x) < $signed(i_y))};
      3'b011: alu_res = {{(XLEN-1){1'b0}}, (i_x < i_y)};
      3'b100: alu_res = i_x ^ i_y;
      3'b101: alu_res = i_op2 ? XLEN'($signed(i_x) >>> shamt) : (i_x >> shamt);
      3'b110: alu_res = i_x | i_y;
      default: alu_res = i_x & i_y;
    endcase
    if (!i_m)
      imm_res = alu_res;
    else if (div_zero)
      imm_res = i_op[1] ? i_x : '1;
    else
      imm_res = i_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // One iteration step: multiply shifts the product right, divide shifts left.
  always_comb begin
    mul_sum  = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, a_q} : '0);
    div_sh   = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
    div_diff = {1'b0, div_sh} - {2'b00, a_q};
    if (state_q == S_MUL)
      step_d = {mul_sum, p_q[XLEN-1:1]};
    else if (div_diff[XLEN+1])
      step_d = {div_sh[XLEN-1:0], p_q[XLEN-2:0], 1'b0};
    else
      step_d = {div_diff[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
  end

  always_comb begin
    mul_fix  = neg_q ? -p_q : p_q;
    div_sel  = op_q[1] ? p_q[2*XLEN-1:XLEN] : p_q[XLEN-1:0];
    div_fix  = neg_q ? -div_sel : div_sel;
    if (div_q)
      fix_res = div_fix;
    else
      fix_res = (op_q == 3'b000) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
    res_load = (accept && (!i_m || special)) || (state_q == S_FIX);
    res_d    = (state_q == S_FIX) ? fix_res : imm_res;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (!i_m || special) state_d = S_DONE;
          else if (is_mul)     state_d = S_MUL;
          else                 state_d = S_DIV;
        end else if (state_q == S_DONE && i_ready) begin
          state_d = S_IDLE;
        end
      end
      S_MUL, S_DIV: if (cnt_q == '0) state_d = S_FIX;
      S_FIX:        state_d = S_DONE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_ready     = (state_q == S_IDLE) || ((state_q == S_DONE) && i_ready);
    o_valid     = (state_q == S_DONE);
    o_result    = res_q;
    o_zero      = zero_q;
    o_dbg_state = state_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      p_q    <= '0;
      a_q    <= '0;
      op_q   <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      res_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      if (accept) begin
        op_q  <= i_op;
        div_q <= is_div;
        neg_q <= neg_d;
        a_q   <= is_mul ? mag_x : mag_y;
        p_q   <= is_mul ? {{XLEN{1'b0}}, mag_y} : {{XLEN{1'b0}}, mag_x};
        cnt_q <= SHW'(XLEN-1);
      end else if (state_q == S_MUL || state_q == S_DIV) begin
        p_q <= step_d;
        if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      end
      if (res_load) begin
        res_q  <= res_d;
        zero_q <= (res_d == '0);
      end
    end
  end

endmodule
